// File: rtl/k_dsp_pkg.sv
// Shared definitions for the K_DSP operand-decode slice: the instruction mode
// encoding, the source-index field offsets and the skid-buffer state encoding.
package k_dsp_pkg;

   // Operand routing mode, taken from instruction[1:0].
   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SWAP   = 2'b01,
      MODE_BCAST  = 2'b10,
      MODE_ZERO2  = 2'b11
   } k_mode_e;

   // LSB positions of the two source-index fields inside the instruction.
   localparam int SEL1_LSB = 2;
   localparam int SEL2_LSB = 8;

   // Occupancy of the 2-entry skid buffer.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_ONE   = 2'b01,
      SKID_TWO   = 2'b10
   } k_skid_state_e;

   // Width of a source index: clog2(n), but never less than one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/k_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The head register drives the output
// directly; the tail register catches the one entry that can arrive while the
// consumer is stalled. in_ready and out_valid are decoded from the state
// register alone, so there is no combinational path from out_ready to in_ready.
//
// Handshake: a word moves on an edge where valid && ready on that side. The
// producer holds data while valid && !ready; out_data is held constant while
// out_valid && !out_ready. Entries leave strictly in arrival order.
module k_skid_buf
   import k_dsp_pkg::*;
#(
   parameter int W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output k_skid_state_e state
);

   logic [W-1:0]  head_q;
   logic [W-1:0]  tail_q;
   k_skid_state_e state_q;
   logic          accept;
   logic          drain;

   assign in_ready  = (state_q != SKID_TWO);
   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = head_q;
   assign state     = state_q;

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

   // Occupancy FSM: moves entries into head/tail and shifts tail to head on drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SKID_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         case (state_q)
            SKID_EMPTY: begin
               if (accept) begin
                  head_q  <= in_data;
                  state_q <= SKID_ONE;
               end
            end
            SKID_ONE: begin
               if (accept && drain) begin
                  // Head leaves and the new entry replaces it on the same edge.
                  head_q <= in_data;
               end else if (accept) begin
                  tail_q  <= in_data;
                  state_q <= SKID_TWO;
               end else if (drain) begin
                  state_q <= SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               if (drain) begin
                  head_q  <= tail_q;
                  state_q <= SKID_ONE;
               end
            end
            default: state_q <= SKID_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/k_operand_decode.sv
// Operand-decode stage for the K_DSP datapath. Decodes mode and two source
// indices from the instruction, selects rs1/rs2 from the loader bus, flags
// out-of-range indices and registers the result through a 2-entry skid buffer.
// Optional feature macro: K_DECODE_STATS_EN adds saturating 16-bit transfer
// counters stat_issued and stat_illegal.
module k_operand_decode
   import k_dsp_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 4,
   parameter int INSTR_W = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSTR_W-1:0]        instruction,
   input  logic [NUM_SRC*DATA_W-1:0] loader_bus,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         rs1,
   output logic [DATA_W-1:0]         rs2,
   output logic                      illegal
`ifdef K_DECODE_STATS_EN
   ,
   output logic [15:0]               stat_issued,
   output logic [15:0]               stat_illegal
`endif
);

   localparam int SEL_W = sel_width(NUM_SRC);
   localparam int PAY_W = 2 * DATA_W + 1;

   k_mode_e           mode;
   logic [SEL_W-1:0]  sel1;
   logic [SEL_W-1:0]  sel2;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic              bad1;
   logic              bad2;
   logic [DATA_W-1:0] dec_rs1;
   logic [DATA_W-1:0] dec_rs2;
   logic              dec_illegal;
   logic [PAY_W-1:0]  out_payload;
   k_skid_state_e     skid_state_unused;
   logic              instr_unused;

   // Only the mode and index fields are decoded; the other bits are don't-care.
   assign instr_unused = ^instruction;

   assign mode = k_mode_e'(instruction[1:0]);
   assign sel1 = instruction[SEL1_LSB +: SEL_W];
   assign sel2 = instruction[SEL2_LSB +: SEL_W];
   assign bad1 = (int'(sel1) >= NUM_SRC);
   assign bad2 = (int'(sel2) >= NUM_SRC);

   // Operand muxes: an out-of-range index matches no channel and yields zero.
   always_comb begin
      op1 = '0;
      op2 = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (int'(sel1) == k) op1 = loader_bus[k*DATA_W +: DATA_W];
         if (int'(sel2) == k) op2 = loader_bus[k*DATA_W +: DATA_W];
      end
   end

   // Mode routing and illegal check; only indices the mode actually uses count.
   always_comb begin
      dec_rs1     = '0;
      dec_rs2     = '0;
      dec_illegal = 1'b0;
      case (mode)
         MODE_DIRECT: begin
            dec_rs1     = op1;
            dec_rs2     = op2;
            dec_illegal = bad1 || bad2;
         end
         MODE_SWAP: begin
            dec_rs1     = op2;
            dec_rs2     = op1;
            dec_illegal = bad1 || bad2;
         end
         MODE_BCAST: begin
            dec_rs1     = op1;
            dec_rs2     = op1;
            dec_illegal = bad1;
         end
         MODE_ZERO2: begin
            dec_rs1     = op1;
            dec_rs2     = '0;
            dec_illegal = bad1;
         end
         default: begin
            dec_rs1     = '0;
            dec_rs2     = '0;
            dec_illegal = 1'b0;
         end
      endcase
      if (dec_illegal) begin
         dec_rs1 = '0;
         dec_rs2 = '0;
      end
   end

   k_skid_buf #(
      .W (PAY_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({dec_illegal, dec_rs2, dec_rs1}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload),
      .state     (skid_state_unused)
   );

   assign rs1     = out_payload[DATA_W-1:0];
   assign rs2     = out_payload[2*DATA_W-1:DATA_W];
   assign illegal = out_payload[PAY_W-1];

`ifdef K_DECODE_STATS_EN
   logic xfer;
   assign xfer = out_valid && out_ready;

   // Saturating counters of output transfers and of illegal output transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued  <= '0;
         stat_illegal <= '0;
      end else if (xfer) begin
         if (stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
         if (illegal && (stat_illegal != 16'hFFFF)) stat_illegal <= stat_illegal + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_k_operand_decode.sv
// Bench for k_operand_decode with NUM_SRC=3 so that index 3 is out of range.
// Drivers push the expected payload {illegal, rs2, rs1} into exp_q on issue;
// a negedge monitor pops and compares on every output transfer.
module tb_k_operand_decode;

   localparam int DW    = 32;
   localparam int NS    = 3;
   localparam int IW    = 32;
   localparam int BUS_W = NS * DW;
   localparam int EXP_W = 2 * DW + 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [IW-1:0]    instruction;
   logic [BUS_W-1:0] loader_bus;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    rs1;
   logic [DW-1:0]    rs2;
   logic             illegal;
`ifdef K_DECODE_STATS_EN
   logic [15:0]      stat_issued;
   logic [15:0]      stat_illegal;
`endif

   k_operand_decode #(
      .DATA_W  (DW),
      .NUM_SRC (NS),
      .INSTR_W (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .loader_bus  (loader_bus),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .rs1         (rs1),
      .rs2         (rs2),
      .illegal     (illegal)
`ifdef K_DECODE_STATS_EN
      ,
      .stat_issued  (stat_issued),
      .stat_illegal (stat_illegal)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int               n_cmp = 0;
   int               n_bad = 0;
   int               cyc = 0;
   int               exp_issued = 0;
   int               exp_illegal = 0;
   bit               streaming = 0;
   int               stream_xfers = 0;
   int               last_xfer_cyc = 0;
   int               gaps = 0;
   bit               hold_prev = 0;
   logic [EXP_W-1:0] prev_pay;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model of the decode, written from the operand-routing rules.
   function automatic logic [EXP_W-1:0] model(input logic [IW-1:0] instr, input logic [BUS_W-1:0] bus);
      int s1;
      int s2;
      logic [DW-1:0] v1;
      logic [DW-1:0] v2;
      logic [DW-1:0] r1;
      logic [DW-1:0] r2;
      logic ill;
      logic [BUS_W-1:0] sh;
      s1 = int'(instr[3:2]);
      s2 = int'(instr[9:8]);
      sh = bus >> (s1 * DW);
      v1 = (s1 < NS) ? sh[DW-1:0] : '0;
      sh = bus >> (s2 * DW);
      v2 = (s2 < NS) ? sh[DW-1:0] : '0;
      case (instr[1:0])
         2'b00:   begin ill = (s1 >= NS) || (s2 >= NS); r1 = v1; r2 = v2; end
         2'b01:   begin ill = (s1 >= NS) || (s2 >= NS); r1 = v2; r2 = v1; end
         2'b10:   begin ill = (s1 >= NS); r1 = v1; r2 = v1; end
         default: begin ill = (s1 >= NS); r1 = v1; r2 = '0; end
      endcase
      if (ill) begin
         r1 = '0;
         r2 = '0;
      end
      return {ill, r2, r1};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         hold_prev = 0;
      end else begin
         if (hold_prev)
            check("hold_stable", {out_valid, illegal, rs2, rs1}, {1'b1, prev_pay});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got %0h expected none", {illegal, rs2, rs1});
            end else begin
               logic [EXP_W-1:0] e;
               e = exp_q.pop_front();
               check("out_data", {illegal, rs2, rs1}, e);
               exp_issued++;
               if (e[EXP_W-1]) exp_illegal++;
            end
            if (streaming) begin
               if (stream_xfers > 0 && (cyc - last_xfer_cyc) != 1) gaps++;
               stream_xfers++;
            end
            last_xfer_cyc = cyc;
         end
         hold_prev = out_valid && !out_ready;
         prev_pay  = {illegal, rs2, rs1};
      end
   end

   // ---------------- driver tasks ----------------
   // Caller is positioned just after a rising edge.
   task automatic send(input logic [IW-1:0] instr, input logic [BUS_W-1:0] bus, input logic [EXP_W-1:0] exp);
      int budget;
      budget      = 0;
      instruction = instr;
      loader_bus  = bus;
      in_valid    = 1'b1;
      while (!in_ready && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 300) begin
         @(posedge clk); #1;
         budget++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   logic [BUS_W-1:0] bus_a;
   logic [BUS_W-1:0] bus_b;
   logic [BUS_W-1:0] bus_c;
   logic [IW-1:0]    r_instr;
   logic [BUS_W-1:0] r_bus;

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      instruction = '0;
      loader_bus  = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset values
      check("rst_out_valid", out_valid, 0);
      check("rst_rs1", rs1, 0);
      check("rst_rs2", rs2, 0);
      check("rst_illegal", illegal, 0);
      check("rst_in_ready", in_ready, 1);

      out_ready = 1'b1;

      // DIRECT sel1=1 sel2=1
      bus_a = {32'hCAFEF00D, 32'h12345678, 32'hA5B6C7D8};
      send(32'h0000_0104, bus_a, {1'b0, 32'h12345678, 32'h12345678});
      check("latency_valid", out_valid, 1);
      check("latency_rs1", rs1, 32'h12345678);

      // SWAP sel1=1 sel2=0
      bus_b = {32'h0BADBEEF, 32'h24681357, 32'h98765432};
      send(32'h0000_0005, bus_b, {1'b0, 32'h24681357, 32'h98765432});
      // DIRECT sel1=3: out of range
      send(32'h0000_000C, bus_b, {1'b1, 32'h0, 32'h0});
      // BCAST sel1=0, sel2=3 ignored
      send(32'h0000_0302, bus_b, {1'b0, 32'h98765432, 32'h98765432});
      // ZERO2 sel1=1, sel2=3 ignored
      send(32'h0000_0307, bus_b, {1'b0, 32'h0, 32'h24681357});
      // SWAP sel2=3: out of range
      send(32'h0000_0301, bus_b, {1'b1, 32'h0, 32'h0});
      // BCAST sel1=3: out of range
      send(32'h0000_000E, bus_b, {1'b1, 32'h0, 32'h0});
      wait_drain();

      // Backpressure: two accepts fill the buffer, third waits
      out_ready = 1'b0;
      bus_c = {32'h33333333, 32'h22222222, 32'h11111111};
      send(32'h0000_0004, bus_c, {1'b0, 32'h11111111, 32'h22222222});
      send(32'h0000_0201, bus_c, {1'b0, 32'h11111111, 32'h33333333});
      check("bp_in_ready", in_ready, 0);
      check("bp_head", {out_valid, illegal, rs2, rs1}, {1'b1, 1'b0, 32'h11111111, 32'h22222222});
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("bp_head_held", rs1, 32'h22222222);
      out_ready = 1'b1;
      send(32'h0000_000A, bus_c, {1'b0, 32'h33333333, 32'h33333333});
      wait_drain();

      // Streaming 100 random inputs
      streaming = 1;
      for (int i = 0; i < 100; i++) begin
         r_instr = $urandom;
         r_bus   = {$urandom, $urandom, $urandom};
         send(r_instr, r_bus, model(r_instr, r_bus));
      end
      wait_drain();
      streaming = 0;
      check("stream_count", stream_xfers, 100);
      check("stream_gaps", gaps, 0);

`ifdef K_DECODE_STATS_EN
      check("stat_issued", stat_issued, exp_issued[15:0]);
      check("stat_illegal", stat_illegal, exp_illegal[15:0]);
`endif

      // Reset while the buffer holds two entries
      out_ready = 1'b0;
      send(32'h0000_0104, bus_a, {1'b0, 32'h12345678, 32'h12345678});
      send(32'h0000_0005, bus_b, {1'b0, 32'h24681357, 32'h98765432});
      check("two_in_ready", in_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_rs1", rs1, 0);
      check("async_rs2", rs2, 0);
      check("async_in_ready", in_ready, 1);
      exp_q.delete();
      exp_issued  = 0;
      exp_illegal = 0;
`ifdef K_DECODE_STATS_EN
      check("rst_stat_issued", stat_issued, 0);
      check("rst_stat_illegal", stat_illegal, 0);
`endif
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("no_stale_output", out_valid, 0);

      // Operation resumes after reset
      send(32'h0000_0006, bus_b, {1'b0, 32'h24681357, 32'h24681357});
      wait_drain();
`ifdef K_DECODE_STATS_EN
      check("resume_stat_issued", stat_issued, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/k_operand_decode.md
# k_operand_decode

Parametrised, pipelined operand-decode stage for the K_DSP datapath. Accepts an instruction word plus NUM_SRC loader operand words, decodes a mode and two source indices from the instruction, and presents the selected rs1/rs2 pair one cycle later. The block sits between the loader bank and the execute unit, with valid/ready handshakes on both sides. A 2-entry skid buffer lets the execute side stall without a combinational ready path.

## Interface
- DATA_W, 32: operand width.
- NUM_SRC, 4: number of loader channels; legal range 2..64.
- INSTR_W, 32: instruction width; minimum 16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction and loader_bus are valid.
- in_ready  out  1  stage can accept; an input is accepted on a cycle where in_valid && in_ready.
- instruction  in  INSTR_W  decode word.
- loader_bus  in  NUM_SRC*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  1  rs1/rs2/illegal are valid.
- out_ready  in  1  consumer accepts; a transfer occurs on a cycle where out_valid && out_ready.
- rs1, rs2  out  DATA_W  selected operands.
- illegal  out  1  the entry at the output had an out-of-range index.

## Operation
- SEL_W = max(1, clog2(NUM_SRC)). Instruction fields: mode = instr[1:0]; sel1 = instr[2 +: SEL_W]; sel2 = instr[8 +: SEL_W]. All other bits are ignored.
- Mode 00 DIRECT: rs1=src[sel1], rs2=src[sel2].
- Mode 01 SWAP: rs1=src[sel2], rs2=src[sel1].
- Mode 10 BCAST: rs1=rs2=src[sel1]; sel2 is ignored, including for the illegal check.
- Mode 11 ZERO2: rs1=src[sel1], rs2=0.
- Illegal: a used index >= NUM_SRC. In that case illegal=1, rs1=rs2=0, and the entry still flows through the handshake.
- Decode and select are combinational on the accepted input. The result is captured into the skid buffer on acceptance.
- Skid buffer states: EMPTY, ONE, TWO.
  - EMPTY: accept goes to ONE.
  - ONE: accept without drain goes to TWO; drain without accept goes to EMPTY; accept with drain stays in ONE.
  - TWO: drain goes to ONE. No accept is possible in TWO.
- Output order is strictly FIFO.

## Timing
- Reset values: out_valid=0, rs1=0, rs2=0, illegal=0, state EMPTY. in_ready=1 from the first edge after rst_n deasserts.
- Latency: an input accepted at edge N is visible on the outputs after edge N, with out_valid=1 in cycle N+1.
- in_ready = (state != TWO). It is registered and does not depend on out_ready.
- Throughput is one transfer per cycle while out_ready=1.
- Output stability: while out_valid && !out_ready, rs1/rs2/illegal must hold constant.
- Simultaneous accept and drain in ONE: the output advances to the new entry on the same edge.
- Reset mid-operation: buffered entries are discarded with no partial output, and the block returns to its reset values asynchronously.
- in_valid may drop without an accept; no state changes when nothing is accepted.

## Configuration
- K_DECODE_STATS_EN defined: adds two outputs, stat_issued and stat_illegal, each 16 bits.
  - stat_issued increments on every output transfer.
  - stat_illegal increments on every output transfer that has illegal=1.
  - Both saturate at 16'hFFFF and reset to 0.
- K_DECODE_STATS_EN undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

## Structure
- Shared package k_dsp_pkg holds:
  - the mode enum (MODE_DIRECT, MODE_SWAP, MODE_BCAST, MODE_ZERO2);
  - the field offset constants SEL1_LSB=2 and SEL2_LSB=8;
  - the skid state encoding.
- One sub-module, k_skid_buf. It is a generic 2-entry valid/ready buffer parametrised by payload width; payload = {illegal, rs2, rs1}.
- Top level contains the decode, the index check and the operand muxes.

## Test plan
- Reset then single DIRECT (NUM_SRC=4): src0=A5B6C7D8, src1=12345678, instr=32'h0000_0104 (sel1=1, sel2=1→) → next cycle out_valid=1, rs1=rs2=12345678, illegal=0.
- SWAP: instr=32'h0000_0005 (sel1=1, sel2=0) with src0=98765432, src1=24681357 → rs1=98765432, rs2=24681357.
- Illegal (NUM_SRC=3): DIRECT with sel1=3 → illegal=1, rs1=rs2=0. Also BCAST with sel2=3, sel1=0 → illegal=0.
- Backpressure: 3 back-to-back inputs with out_ready=0 → in_ready=0 after 2 accepts and outputs held stable. Raise out_ready → all 3 emerge in order with no loss.
- Streaming: out_ready=1, 100 random inputs → 100 outputs in order at 1 per cycle, matching a reference model.
- rst_n pulsed low while the buffer is in state TWO → out_valid drops immediately, in_ready=1 after release, no stale output. With K_DECODE_STATS_EN defined, both counters read 0.
